// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit sharing the EX stage with the ALU.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(XLEN-1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              neg_r_q, neg_r_d;
  logic [XLEN-1:0]   opr_q, opr_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div0, ovf, fast;
  logic [XLEN-1:0] div_fast, fast_res;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      funct3_i == 3'b001: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      funct3_i == 3'b010: a_sgn = 1'b1;
      funct3_i[2] & ~funct3_i[0]: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      default: ;
    endcase
  end

  assign a_neg = a_sgn & op_a_i[XLEN-1];
  assign b_neg = b_sgn & op_b_i[XLEN-1];
  assign a_mag = a_neg ? -op_a_i : op_a_i;
  assign b_mag = b_neg ? -op_b_i : op_b_i;

  assign div0 = (op_b_i == '0);
  assign ovf  = a_sgn & funct3_i[2]
              & (op_a_i == MIN_INT)
              & (&op_b_i);

  always_comb begin
    if (div0)
      div_fast = funct3_i[1] ? op_a_i : '1;
    else
      div_fast = funct3_i[1] ? '0 : MIN_INT;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended 64-bit operands: the true
  // product always fits, so low 64 bits are exact.
  logic [2*XLEN-1:0] fa, fb, fp;
  logic [XLEN-1:0]   mul_res;

  assign fa = {{XLEN{a_neg}}, op_a_i};
  assign fb = {{XLEN{b_neg}}, op_b_i};
  assign fp = fa * fb;
  assign mul_res = (funct3_i == 3'b000)
                 ? fp[XLEN-1:0]
                 : fp[2*XLEN-1:XLEN];
  assign fast = ~funct3_i[2] | div0 | ovf;
  assign fast_res = funct3_i[2] ? div_fast
                                : mul_res;
`else
  assign fast = funct3_i[2] & (div0 | ovf);
  assign fast_res = div_fast;
`endif

  // one shift-add or restoring-divide step
  logic [XLEN:0]     sum, sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt;
  logic              unused_diff;

  assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + (acc_q[0] ? {1'b0, opr_q} : '0);
  assign mul_nxt = {sum, acc_q[XLEN-1:1]};

  assign sh   = {acc_q[2*XLEN-1:XLEN],
                 acc_q[XLEN-1]};
  assign diff = {1'b0, sh} - {2'b0, opr_q};
  assign div_nxt = diff[XLEN+1]
    ? {sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
    : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign unused_diff = diff[XLEN];

  assign acc_nxt = f3_q[2] ? div_nxt : mul_nxt;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin;

  assign prod = neg_q ? -mul_nxt : mul_nxt;
  assign quo  = neg_q ? -div_nxt[XLEN-1:0]
                      : div_nxt[XLEN-1:0];
  assign rem  = neg_r_q
              ? -div_nxt[2*XLEN-1:XLEN]
              : div_nxt[2*XLEN-1:XLEN];

  always_comb begin
    if (f3_q[2])
      fin = f3_q[1] ? rem : quo;
    else if (f3_q[1:0] == 2'b00)
      fin = prod[XLEN-1:0];
    else
      fin = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    neg_r_d = neg_r_q;
    opr_d   = opr_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !kill_i) begin
          f3_d    = funct3_i;
          neg_d   = a_neg ^ b_neg;
          neg_r_d = a_neg;
          cnt_d   = '0;
          opr_d   = funct3_i[2] ? b_mag : a_mag;
          acc_d   = {{XLEN{1'b0}},
                     funct3_i[2] ? a_mag : b_mag};
          if (fast) begin
            res_d   = fast_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            res_d   = fin;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      opr_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      neg_r_q <= neg_r_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = (state_q == CALC);
  assign done_o   = (state_q == DONE) & ~kill_i;
  assign result_o = res_q;

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the combinational ALU.
- Decode routes R-type instructions with funct7 = 0000001 here instead of to the ALU-control path.
- Consumes the same funct3 field and the forwarded rs1/rs2 operands.
- Raises busy_o so the hazard unit stalls IF/ID/EX until the result is ready for EX/MEM.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk_i  input  1  core clock. All state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  valid M-extension instruction present in EX. Sampled only in IDLE.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  input  XLEN  rs1 value after forwarding.
- op_b_i  input  XLEN  rs2 value after forwarding.
- kill_i  input  1  pipeline flush (branch taken or trap). Aborts the operation in flight.
- busy_o  output  1  high while an operation is in flight. Drives the stall.
- done_o  output  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  output  XLEN  final result. Held until the next accepted start.

Behaviour:
- Reset (synchronous, rst_i = 1 at posedge):
  - state = IDLE.
  - busy_o = 0, done_o = 0, result_o = 0, counter = 0.
  - Reset has priority over kill_i and start_i, and aborts any in-flight operation.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start_i = 1 in cycle T latches operands, funct3, and sign flags.
  - Normal operations go to CALC in T+1.
  - Fast-path cases go straight to DONE in T+1.
  - busy_o = 0 in IDLE.
- CALC:
  - busy_o = 1.
  - Exactly XLEN iterations (counter 0..31), one per cycle.
  - Multiply: radix-2 shift-add on operand magnitudes into a 2*XLEN product register.
  - Divide: restoring radix-2 on magnitudes, producing quotient and remainder registers.
  - At counter = 31, sign correction is applied and the next state is DONE.
- DONE:
  - done_o = 1 and busy_o = 0 for exactly one cycle.
  - result_o is updated at entry to DONE; next state is IDLE.
  - start_i seen in DONE is ignored; the pipeline advances first.
- Latency: normal operation, start at T, done_o at T+33. Fast path, done_o at T+1.
- Sign and width rules:
  - MUL: low 32 bits of the product.
  - MULH: signed × signed, high 32 bits.
  - MULHSU: signed rs1 × unsigned rs2, high 32 bits.
  - MULHU: unsigned × unsigned, high 32 bits.
  - Signed product is negated when the operand signs differ.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Fast path (RISC-V spec values):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (DIV/REM with a = 0x80000000, b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- kill_i:
  - kill_i = 1 in CALC or DONE forces IDLE next cycle with no done_o pulse; result_o is unchanged.
  - kill_i = 1 together with start_i in IDLE blocks acceptance.
- start_i while busy is ignored. Operands are taken from the latched copies only, so forwarded inputs may change freely during CALC.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 33×33 signed multiplier and go IDLE → DONE.
  - done_o at T+1.
  - Divide operations are unchanged.
- Undefined:
  - Multiplies use the iterative CALC path, done_o at T+33.
  - No hardware multiplier is inferred.

Test Plan:
- Reset mid-CALC: start MUL 3×4, assert rst_i at T+10 → busy_o = 0, done_o = 0, result_o = 0 next cycle; no done pulse follows.
- MUL and MULH: a = 0xFFFFFFFE (-2), b = 3.
  - MUL → result_o = 0xFFFFFFFA, done_o at T+33 (T+1 with MULDIV_FAST_MUL_EN).
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000002.
- DIV/REM signed: a = -7 (0xFFFFFFF9), b = 2.
  - DIV → 0xFFFFFFFD (-3).
  - REM → 0xFFFFFFFF (-1).
  - DIVU → 0x7FFFFFFC.
- Divide by zero: DIVU a = 5, b = 0 → 0xFFFFFFFF at T+1. REMU → 5 at T+1. busy_o never high.
- Overflow: DIV a = 0x80000000, b = 0xFFFFFFFF → 0x80000000 at T+1. REM → 0.
- Kill and ignored start:
  - Start DIVU 100/7, kill_i at T+5 → no done_o; result_o retains its prior value.
  - start_i pulsed during CALC of another op → ignored; the original op completes at T+33 with the correct result.
